// File: rtl/display7seg_mux.sv
// Multiplexed N-digit 7-segment driver: hex/BCD decode, blanked digit scanning, frame-synchronous double-buffered load.
// Optional blink support is compiled in with `define DISPLAY7SEG_MUX_BLINK_EN.
module display7seg_mux #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
`ifdef DISPLAY7SEG_MUX_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
`ifdef DISPLAY7SEG_MUX_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  pending
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int              IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);
    localparam logic            POL      = ACTIVE_LOW;

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         index;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   active;
    logic [DIGITS-1:0]     shadow_dp;
    logic [DIGITS-1:0]     active_dp;

    logic                  tick;
    logic                  frame_end;

    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic                  sel_blank;
    logic                  sel_dark;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [DIGITS-1:0]     an_next;

    assign tick      = (prescaler == PRE_LAST);
    assign frame_end = tick && (index == IDX_LAST);

    // Segments are {a,b,c,d,e,f,g}, active-high here; polarity is applied at the output register.
    function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        if (!hex && (code > 4'd9)) begin
            s = 7'b0000000;
        end
        return s;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            active    <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (load) begin
                shadow    <= data;
                shadow_dp <= dp;
            end

            // A load landing on the boundary bypasses the shadow so it is never one frame late.
            if (frame_end && load) begin
                active    <= data;
                active_dp <= dp;
                pending   <= 1'b0;
            end else if (frame_end && pending) begin
                active    <= shadow;
                active_dp <= shadow_dp;
                pending   <= 1'b0;
            end else if (load) begin
                pending   <= 1'b1;
            end
        end
    end

`ifdef DISPLAY7SEG_MUX_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin : select_digit
        logic zero_run;
        zero_run   = 1'b1;
        sel_nibble = 4'd0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        sel_dark   = 1'b0;
        an_next    = '0;
        // Walk from the most significant digit so zero_run means "this and all higher nibbles are zero".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (active[4*i +: 4] == 4'd0);
            an_next[i] = (prescaler != '0) && (index == IW'(i));
            if (index == IW'(i)) begin
                sel_nibble = active[4*i +: 4];
                sel_dp     = active_dp[i];
                sel_blank  = blank_lz && (i != 0) && zero_run;
`ifdef DISPLAY7SEG_MUX_BLINK_EN
                sel_dark   = !blink_on && blink_mask[i];
`endif
            end
        end
        seg_next = (sel_blank || sel_dark) ? 7'b0000000 : decode(sel_nibble, hex_mode);
        dp_next  = sel_dp && !sel_dark;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg    <= {7{POL}};
            dp_out <= POL;
            an     <= {DIGITS{POL}};
        end else begin
            seg    <= seg_next ^ {7{POL}};
            dp_out <= dp_next ^ POL;
            an     <= an_next ^ {DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_display7seg_mux.sv
// Directed bench for display7seg_mux: an active-high and an active-low instance share stimulus.
// Edges are numbered from reset release; outputs are sampled 1 ns after each rising edge.
module tb_display7seg_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        hex_mode;
    logic        blank_lz;

    logic [6:0]  seg_h;
    logic        dp_out_h;
    logic [3:0]  an_h;
    logic        pending_h;
    logic [6:0]  seg_l;
    logic        dp_out_l;
    logic [3:0]  an_l;
    logic        pending_l;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    display7seg_mux #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .hex_mode(hex_mode), .blank_lz(blank_lz),
        .seg(seg_h), .dp_out(dp_out_h), .an(an_h), .pending(pending_h)
    );

    display7seg_mux #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .hex_mode(hex_mode), .blank_lz(blank_lz),
        .seg(seg_l), .dp_out(dp_out_l), .an(an_l), .pending(pending_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
            edge_cnt++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        data     = 16'h0000;
        dp       = 4'b0000;
        hex_mode = 1'b1;
        blank_lz = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("rst_an_h",      32'(an_h),      32'h0);
        check("rst_seg_h",     32'(seg_h),     32'h0);
        check("rst_dp_h",      32'(dp_out_h),  32'h0);
        check("rst_pending_h", 32'(pending_h), 32'h0);
        check("rst_an_l",      32'(an_l),      32'hF);
        check("rst_seg_l",     32'(seg_l),     32'h7F);
        check("rst_dp_l",      32'(dp_out_l),  32'h1);

        // Scan order with blanking slot at prescaler==0
        reset = 1'b0;
        edge_cnt = 0;
        goto_edge(1);  check("scan_e1_an", 32'(an_h), 32'b0000);
        goto_edge(2);  check("scan_e2_an", 32'(an_h), 32'b0001);
                       check("scan_e2_seg", 32'(seg_h), 32'b1111110);
        goto_edge(3);  check("scan_e3_an", 32'(an_h), 32'b0001);
        goto_edge(4);  check("scan_e4_an", 32'(an_h), 32'b0001);
        goto_edge(5);  check("scan_e5_an", 32'(an_h), 32'b0000);
        goto_edge(6);  check("scan_e6_an", 32'(an_h), 32'b0010);
                       check("scan_e6_seg", 32'(seg_h), 32'b1111110);

        // Mid-frame load of 1234 shows only after the frame boundary at edge 16
        data = 16'h1234;
        load = 1'b1;
        goto_edge(7);  load = 1'b0;
                       check("load_pending_set", 32'(pending_h), 32'h1);
        goto_edge(10); check("old_d2_an", 32'(an_h), 32'b0100);
                       check("old_d2_seg", 32'(seg_h), 32'b1111110);
                       check("old_pending", 32'(pending_h), 32'h1);
        goto_edge(16); check("boundary_pending_clr", 32'(pending_h), 32'h0);
        goto_edge(18); check("new_d0_an", 32'(an_h), 32'b0001);
                       check("new_d0_seg", 32'(seg_h), 32'b0110011);
        goto_edge(30); check("new_d3_an", 32'(an_h), 32'b1000);
                       check("new_d3_seg", 32'(seg_h), 32'b0110000);

        // BCD mode with leading-zero blanking on 00A7, applied at edge 32
        hex_mode = 1'b0;
        blank_lz = 1'b1;
        data = 16'h00A7;
        load = 1'b1;
        goto_edge(31); load = 1'b0;
                       check("bcd_pending", 32'(pending_h), 32'h1);
        goto_edge(34); check("bcd_d0_seg", 32'(seg_h), 32'b1110000);
        goto_edge(38); check("bcd_d1_an", 32'(an_h), 32'b0010);
                       check("bcd_d1_seg", 32'(seg_h), 32'b0000000);
        goto_edge(42); check("lz_d2_an", 32'(an_h), 32'b0100);
                       check("lz_d2_seg", 32'(seg_h), 32'b0000000);
        goto_edge(46); check("lz_d3_an", 32'(an_h), 32'b1000);
                       check("lz_d3_seg", 32'(seg_h), 32'b0000000);

        // Load exactly on the boundary edge 48: direct to active, pending never rises
        goto_edge(47);
        hex_mode = 1'b1;
        blank_lz = 1'b0;
        data = 16'hBEEF;
        load = 1'b1;
        goto_edge(48); load = 1'b0;
                       check("bnd_pending_e48", 32'(pending_h), 32'h0);
        goto_edge(50); check("beef_d0_seg", 32'(seg_h), 32'b1000111);
                       check("bnd_pending_e50", 32'(pending_h), 32'h0);
        goto_edge(54); check("beef_d1_seg", 32'(seg_h), 32'b1001111);
        goto_edge(58); check("beef_d2_seg", 32'(seg_h), 32'b1001111);
        goto_edge(62); check("beef_d3_seg", 32'(seg_h), 32'b0011111);
                       check("bnd_pending_e62", 32'(pending_h), 32'h0);

        // Reset mid-slot while a load is pending
        data = 16'h9999;
        load = 1'b1;
        goto_edge(63); load = 1'b0;
                       check("pre_rst_pending", 32'(pending_h), 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_an_h",      32'(an_h),      32'h0);
        check("async_rst_seg_h",     32'(seg_h),     32'h0);
        check("async_rst_dp_h",      32'(dp_out_h),  32'h0);
        check("async_rst_pending_h", 32'(pending_h), 32'h0);
        check("async_rst_an_l",      32'(an_l),      32'hF);
        check("async_rst_seg_l",     32'(seg_l),     32'h7F);
        @(posedge clk); #1;
        reset = 1'b0;
        edge_cnt = 0;
        goto_edge(2);  check("post_rst_an", 32'(an_h), 32'b0001);
                       check("post_rst_seg", 32'(seg_h), 32'b1111110);
                       check("post_rst_pending", 32'(pending_h), 32'h0);
                       check("post_rst_seg_l", 32'(seg_l), 32'b0000001);
                       check("post_rst_an_l", 32'(an_l), 32'b1110);

        // Two back-to-back loads: the second (0000, dp on digit 0) must win
        data = 16'h1111;
        dp   = 4'b0000;
        load = 1'b1;
        goto_edge(3);  data = 16'h0000;
                       dp   = 4'b0001;
        goto_edge(4);  load = 1'b0;
                       check("lastwin_pending", 32'(pending_h), 32'h1);
        goto_edge(14); check("lastwin_old_seg", 32'(seg_h), 32'b1111110);
        goto_edge(16); check("lastwin_pending_clr", 32'(pending_h), 32'h0);
        goto_edge(18); check("al_d0_an_l", 32'(an_l), 32'b1110);
                       check("al_d0_dp_l", 32'(dp_out_l), 32'h0);
                       check("al_d0_seg_l", 32'(seg_l), 32'b0000001);
                       check("ah_d0_dp_h", 32'(dp_out_h), 32'h1);
        goto_edge(30); check("al_d3_an_l", 32'(an_l), 32'b0111);
                       check("al_d3_seg_l", 32'(seg_l), 32'b0000001);
                       check("al_d3_dp_l", 32'(dp_out_l), 32'h1);
        goto_edge(33); check("al_blank_an_l", 32'(an_l), 32'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display7seg_mux.md
Name: display7seg_mux

Overview:
Multiplexed N-digit 7-segment display driver; successor to the single-digit combinational decoder.
- Full hex or BCD decode per digit, parametrised digit count and segment polarity.
- Time-multiplexed digit scanning with an inter-digit blanking slot.
- Double-buffered value load; updates apply only at frame boundaries, so frames never tear.
- Sits between counter/FSM logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
PRESCALE, 50000, clk cycles per digit slot (>=2)
ACTIVE_LOW, 1, 1: seg/an/dp_out driven active-low; 0: active-high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load  in  1  capture data/dp into shadow register this cycle
data  in  4*DIGITS  nibble i = digit i (digit 0 least significant, rightmost)
dp  in  DIGITS  decimal point per digit, 1 = lit
hex_mode  in  1  1: codes 0-F decoded; 0: BCD, codes 10-15 blank
blank_lz  in  1  1: blank leading zeros
seg  out  7  {a,b,c,d,e,f,g}, seg[6]=a
dp_out  out  1  decimal point of the selected digit
an  out  DIGITS  digit enables, one-hot when active
pending  out  1  shadow holds data not yet shown

Behaviour:
- Reset (async): prescaler=0, index=0, shadow=0, active=0, shadow/active dp=0, pending=0. All outputs at the inactive level: seg, dp_out and an all off.
- All outputs are registered and reflect the active register, index and prescaler of the previous cycle.
- Prescaler counts 0..PRESCALE-1 and wraps. On the cycle it equals PRESCALE-1 ("tick"), index increments, wrapping DIGITS-1 -> 0.
- Blanking slot: while prescaler==0, an is all off. The rest of the slot drives an one-hot on the index digit.
- Frame boundary = tick with index==DIGITS-1.
- load=1 captures shadow<=data and shadow dp<=dp; pending=1 the next cycle. A repeated load overwrites shadow; last load wins.
- At a frame boundary with pending=1: active<=shadow, pending<=0.
- load coinciding with a frame boundary: active<=data/dp directly, shadow updated as well, pending=0.
- Decode, seg active-high before polarity:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- hex_mode=0 with code 10-15: seg all off; dp still honoured.
- Leading-zero blanking (blank_lz=1): digit i>0 is blank (seg off, an still driven) if its nibble and every higher nibble are 0. Digit 0 is never blanked. dp is unaffected.
- hex_mode and blank_lz are sampled live, not buffered.
- ACTIVE_LOW=1 inverts seg, dp_out and an at the output register.
- Reset mid-frame: immediate return to reset state; a pending load is discarded.

Optional Feature:
Macro DISPLAY7SEG_MUX_BLINK_EN.
- Defined:
  - Adds input blink_mask [DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles blink phase every BLINK_FRAMES frame boundaries.
  - In the off phase, masked digits have seg and dp_out off; scanning timing is unchanged.
  - Reset clears the counter and sets phase = on.
- Undefined: no port, no counter; behaviour as above.

Test Plan:
- DIGITS=4, PRESCALE=4, ACTIVE_LOW=0; reset released, no load -> an sequence 0000,0001,0001,0001,0000,0010... and digit 0 seg=1111110 (other digits also 0, blank_lz=0).
- load data=16'h1234 mid-frame -> pending=1 next cycle; old value displayed until frame boundary; then pending=0 and digit3 seg=0110000, digit0 seg=0110011.
- hex_mode=0, data=16'h00A7, blank_lz=1 -> digits 3,2 seg off; digit1 (A) seg off (invalid BCD); digit0 seg=1110000.
- load asserted exactly on frame-boundary cycle with data=16'hBEEF -> next frame shows B,E,E,F; pending never rises.
- Assert reset while pending=1 mid-slot -> same cycle outputs off, pending=0; after release display shows 0000.
- ACTIVE_LOW=1, dp=4'b0001, data=0 -> during digit 0 slot an=1110, dp_out=0, seg=0000001.
